// File: rtl/snake_pkg.sv
// Shared types, grid constants and coordinate helpers for the snake engine.
// The grid is square; coordinates are (row, col) with row 0 at the top.
package snake_pkg;

  localparam int GRID = 16;
  localparam int CW   = $clog2(GRID);
  localparam logic [CW-1:0] EDGE_MAX = CW'(GRID - 1);

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  typedef struct packed {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } coord_t;

  typedef struct packed {
    coord_t pos;
    logic   oob;
  } step_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    case (d)
      UP:      o = DOWN;
      DOWN:    o = UP;
      LEFT:    o = RIGHT;
      RIGHT:   o = LEFT;
      default: o = LEFT;
    endcase
    return o;
  endfunction

  // pos wraps on the edge; callers must honour oob rather than the wrapped cell
  function automatic step_t step(input coord_t c, input dir_t d);
    step_t s;
    s.pos = c;
    s.oob = 1'b0;
    case (d)
      UP: begin
        s.oob     = (c.row == '0);
        s.pos.row = c.row - CW'(1);
      end
      DOWN: begin
        s.oob     = (c.row == EDGE_MAX);
        s.pos.row = c.row + CW'(1);
      end
      LEFT: begin
        s.oob     = (c.col == '0);
        s.pos.col = c.col - CW'(1);
      end
      RIGHT: begin
        s.oob     = (c.col == EDGE_MAX);
        s.pos.col = c.col + CW'(1);
      end
      default: s.oob = 1'b1;
    endcase
    return s;
  endfunction

  function automatic coord_t init_cell(input int idx, input int init_len);
    coord_t c;
    c.row = CW'(GRID / 2);
    c.col = CW'(GRID / 2 - 1 - init_len + idx);
    return c;
  endfunction

  function automatic logic [GRID-1:0][GRID-1:0] init_bitmap(input int init_len);
    logic [GRID-1:0][GRID-1:0] b;
    coord_t c;
    b = '0;
    for (int i = 0; i < init_len; i++) begin
      c = init_cell(i, init_len);
      b[c.row][c.col] = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/snake_ring_buffer.sv
// Circular buffer of snake body coordinates; head_o is the newest entry and
// tail_o the oldest. Push and pop may happen in the same cycle.
module snake_ring_buffer
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  coord_t push_data_i,
  input  logic   pop_i,
  output coord_t head_o,
  output coord_t tail_o
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(MAX_LEN - 1);

  coord_t        mem_q [MAX_LEN];
  logic [PW-1:0] head_ptr_q;
  logic [PW-1:0] head_ptr_d;
  logic [PW-1:0] tail_ptr_q;
  logic [PW-1:0] tail_ptr_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Pointer advance
  always_comb begin
    head_ptr_d = push_i ? ptr_inc(head_ptr_q) : head_ptr_q;
    tail_ptr_d = pop_i  ? ptr_inc(tail_ptr_q) : tail_ptr_q;
  end

  // Storage and pointers; reset loads the initial horizontal body
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr_q <= PW'(INIT_LEN - 1);
      tail_ptr_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= (i < INIT_LEN) ? init_cell(i, INIT_LEN) : '0;
      end
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      if (push_i) begin
        mem_q[head_ptr_d] <= push_data_i;
      end
    end
  end

  assign head_o = mem_q[head_ptr_q];
  assign tail_o = mem_q[tail_ptr_q];

endmodule

// File: rtl/snake_engine.sv
// Snake movement engine: direction latch, move/collision logic, occupancy
// bitmap and RUN/DEAD state machine. lights goes all-zero on death.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir_in,
  input  logic                           apple_valid,
  input  logic [3:0]                     apple_row,
  input  logic [3:0]                     apple_col,
  output logic [GRID-1:0][GRID-1:0]      lights,
  output logic                           ate,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           dead
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t                    state_q;
  state_t                    state_d;
  dir_t                      cur_dir_q;
  dir_t                      cur_dir_d;
  dir_t                      pend_dir_q;
  dir_t                      pend_dir_d;
  logic [GRID-1:0][GRID-1:0] lights_q;
  logic [GRID-1:0][GRID-1:0] lights_d;
  logic [LW-1:0]             length_q;
  logic [LW-1:0]             length_d;
  logic                      ate_q;
  logic                      ate_d;
  logic                      dead_q;
  logic                      dead_d;

  coord_t head_s;
  coord_t tail_s;
  coord_t apple_s;
  step_t  step_s;
  dir_t   dir_req_s;
  logic   grow_s;
  logic   body_hit_s;
  logic   tail_hit_s;
  logic   self_hit_s;
  logic   die_s;
  logic   move_ok_s;
  logic   room_s;
  logic   push_s;
  logic   pop_s;

  snake_ring_buffer #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (step_s.pos),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .tail_o      (tail_s)
  );

  assign dir_req_s = dir_t'(dir_in);
  assign apple_s   = {apple_row, apple_col};

  // Move evaluation: the tail cell is free unless the snake grows this move
  always_comb begin
    step_s     = step(head_s, pend_dir_q);
    grow_s     = apple_valid && (step_s.pos == apple_s);
    body_hit_s = lights_q[step_s.pos.row][step_s.pos.col];
    tail_hit_s = (step_s.pos == tail_s);
    self_hit_s = body_hit_s && !(tail_hit_s && !grow_s);
    room_s     = (length_q < LW'(MAX_LEN));
    die_s      = (state_q == ST_RUN) && tick && (step_s.oob || self_hit_s);
    move_ok_s  = (state_q == ST_RUN) && tick && !die_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  state_d = die_s ? ST_DEAD : ST_RUN;
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs and datapath next-state; a saturated grow still pops the tail
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    ate_d      = 1'b0;
    length_d   = length_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    lights_d   = lights_q;
    dead_d     = (state_d == ST_DEAD);
    case (state_q)
      ST_RUN: begin
        if (dir_valid && (dir_req_s != opposite(cur_dir_q))) begin
          pend_dir_d = dir_req_s;
        end else begin
          pend_dir_d = pend_dir_q;
        end
        if (die_s) begin
          lights_d = '0;
        end else if (move_ok_s) begin
          push_s    = 1'b1;
          pop_s     = !(grow_s && room_s);
          ate_d     = grow_s;
          length_d  = (grow_s && room_s) ? length_q + LW'(1) : length_q;
          cur_dir_d = pend_dir_q;
          lights_d[tail_s.row][tail_s.col] = lights_q[tail_s.row][tail_s.col] & !pop_s;
          lights_d[step_s.pos.row][step_s.pos.col] = 1'b1;
        end else begin
          lights_d = lights_q;
        end
      end
      ST_DEAD: lights_d = '0;
      default: lights_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_dir_q  <= RIGHT;
      pend_dir_q <= RIGHT;
      lights_q   <= init_bitmap(INIT_LEN);
      length_q   <= LW'(INIT_LEN);
      ate_q      <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      lights_q   <= lights_d;
      length_q   <= length_d;
      ate_q      <= ate_d;
      dead_q     <= dead_d;
    end
  end

  assign lights = lights_q;
  assign length = length_q;
  assign ate    = ate_q;
  assign dead   = dead_q;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: a behavioural snake model predicts
// each cycle's outputs into a scoreboard that is compared after the edge.
module tb_snake_engine;

  localparam int MAXL = 64;
  localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

  logic              clk = 1'b0;
  logic              reset, tick, dir_valid, apple_valid;
  logic [1:0]        dir_in;
  logic [3:0]        apple_row, apple_col;
  logic [15:0][15:0] lights;
  logic              ate, dead;
  logic [6:0]        length;

  snake_engine #(.MAX_LEN(MAXL), .INIT_LEN(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .dir_valid(dir_valid), .dir_in(dir_in),
    .apple_valid(apple_valid), .apple_row(apple_row), .apple_col(apple_col),
    .lights(lights), .ate(ate), .length(length), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] lights;
    logic [6:0]   length;
    logic         ate;
    logic         dead;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  int br[$];
  int bc[$];
  int m_dir, m_pend, m_len;
  bit m_dead, m_ate;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int opp(input int d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  function automatic int dr(input int d);
    return (d == D_UP) ? -1 : (d == D_DOWN) ? 1 : 0;
  endfunction

  function automatic int dc(input int d);
    return (d == D_LEFT) ? -1 : (d == D_RIGHT) ? 1 : 0;
  endfunction

  function automatic bit occupied(input int r, input int c);
    foreach (br[i]) if (br[i] == r && bc[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [255:0] model_lights();
    logic [255:0] v = '0;
    if (!m_dead) foreach (br[i]) v[br[i]*16 + bc[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    br = {8, 8, 8};
    bc = {4, 5, 6};
    m_dir = D_RIGHT; m_pend = D_RIGHT; m_len = 3; m_dead = 1'b0; m_ate = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit dv, input int d, input bit av, input int ar, input int ac);
    int od, hr, hc;
    bit grow;
    m_ate = 1'b0;
    if (m_dead) return;
    od = m_dir;
    if (tk) begin
      hr = br[$] + dr(m_pend);
      hc = bc[$] + dc(m_pend);
      m_dir = m_pend;
      grow = av && hr == ar && hc == ac;
      if (hr < 0 || hr > 15 || hc < 0 || hc > 15) m_dead = 1'b1;
      else if (occupied(hr, hc) && !(hr == br[0] && hc == bc[0] && !grow)) m_dead = 1'b1;
      else begin
        if (!grow || m_len == MAXL) begin
          void'(br.pop_front());
          void'(bc.pop_front());
        end
        br.push_back(hr);
        bc.push_back(hc);
        m_len = br.size();
        m_ate = grow;
      end
    end
    if (dv && d != opp(od)) m_pend = d;
  endtask

  task automatic cycle(input bit rst, input bit tk, input bit dv, input int d,
                       input bit av, input int ar, input int ac);
    exp_t e, g;
    reset = rst; tick = tk; dir_valid = dv; dir_in = 2'(d);
    apple_valid = av; apple_row = 4'(ar); apple_col = 4'(ac);
    if (rst) model_reset();
    else model_step(tk, dv, d, av, ar, ac);
    e.lights = model_lights();
    e.length = 7'(m_len);
    e.ate    = m_ate;
    e.dead   = m_dead;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      g = exp_q.pop_front();
      chk("sb_lights", lights, g.lights);
      chk("sb_length", length, g.length);
      chk("sb_ate", ate, g.ate);
      chk("sb_dead", dead, g.dead);
    end
  endtask

  task automatic do_reset();  cycle(1'b1, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();      cycle(1'b0, 0, 0, 0, 0, 0, 0); endtask
  task automatic step_t_(input int d); cycle(1'b0, 1, 0, d, 0, 0, 0); endtask
  task automatic set_dir(input int d); cycle(1'b0, 0, 1, d, 0, 0, 0); endtask
  task automatic eat(input int r, input int c); cycle(1'b0, 1, 0, 0, 1, r, c); endtask

  int loop_dirs[4] = '{D_DOWN, D_LEFT, D_UP, D_RIGHT};

  initial begin
    logic [255:0] rst_pat;
    rst_pat = '0;
    rst_pat[143:128] = 16'h0070;

    // reset release
    do_reset();
    chk("rst_lights", lights, rst_pat);
    chk("rst_row8", lights[8], 16'h0070);
    chk("rst_len", length, 7'd3);
    chk("rst_dead", dead, 1'b0);
    chk("rst_ate", ate, 1'b0);

    // straight move
    for (int i = 0; i < 3; i++) begin
      step_t_(0);
      idle();
    end
    chk("straight_row8", lights[8], 16'h0380);
    chk("straight_len", length, 7'd3);

    // eat apple at (8,7)
    do_reset();
    eat(8, 7);
    chk("eat_ate", ate, 1'b1);
    chk("eat_len", length, 7'd4);
    chk("eat_row8", lights[8], 16'h00F0);
    idle();
    chk("eat_ate_drop", ate, 1'b0);
    step_t_(0);
    chk("eat_len_hold", length, 7'd4);
    chk("eat_row8_next", lights[8], 16'h01E0);

    // reversal dropped
    do_reset();
    set_dir(D_LEFT);
    step_t_(0);
    chk("rev_row8", lights[8], 16'h00E0);
    chk("rev_dead", dead, 1'b0);

    // same-cycle dir and tick: tick uses the old direction
    do_reset();
    cycle(1'b0, 1, 1, D_UP, 0, 0, 0);
    chk("same_row8", lights[8], 16'h00E0);
    step_t_(0);
    chk("same_row7", lights[7], 16'h0080);
    chk("same_row8b", lights[8], 16'h00C0);

    // wall death going up
    do_reset();
    set_dir(D_UP);
    for (int i = 0; i < 8; i++) step_t_(0);
    chk("wall_alive", dead, 1'b0);
    chk("wall_row0", lights[0], 16'h0040);
    step_t_(0);
    chk("wall_dead", dead, 1'b1);
    chk("wall_dark", lights, 256'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1, 1, i, 1, 0, 6);
    chk("wall_still_dark", lights, 256'h0);
    chk("wall_len_frozen", length, 7'd3);

    // self collision after growing to 5
    do_reset();
    eat(8, 7);
    eat(8, 8);
    chk("self_len5", length, 7'd5);
    set_dir(D_DOWN);  step_t_(0);
    set_dir(D_LEFT);  step_t_(0);
    set_dir(D_UP);    step_t_(0);
    chk("self_dead", dead, 1'b1);
    chk("self_dark", lights, 256'h0);

    // reset out of DEAD
    do_reset();
    chk("redo_lights", lights, rst_pat);
    chk("redo_dead", dead, 1'b0);

    // tail chase on a 2x2 loop
    eat(8, 7);
    for (int k = 0; k < 8; k++) begin
      set_dir(loop_dirs[k % 4]);
      step_t_(0);
    end
    chk("chase_dead", dead, 1'b0);
    chk("chase_len", length, 7'd4);
    chk("chase_row8", lights[8], 16'h00C0);
    chk("chase_row9", lights[9], 16'h00C0);

    // random play against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit rst, tk, dv, av;
      int d, ar, ac;
      rst = m_dead && ($urandom_range(0, 3) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      dv  = $urandom_range(0, 1);
      d   = $urandom_range(0, 3);
      av  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) begin
        ar = (br[$] + dr(m_pend)) & 15;
        ac = (bc[$] + dc(m_pend)) & 15;
      end else begin
        ar = $urandom_range(0, 15);
        ac = $urandom_range(0, 15);
      end
      cycle(rst, tk, dv, d, av, ar, ac);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
